// File: rtl/sine_rom_arbiter.sv
// sine_rom_arbiter: 4-way round-robin arbiter in front of a single-port ROM
// that has one cycle of read latency.
// Grants are combinational in the accepting cycle. The ROM is driven in the
// same cycle as the grant, and read data is returned with the owner's index.
// Optional macro SINE_ROM_ARB_OUTREG_EN adds one register stage on
// rdata/rdata_valid/rdata_id, which makes the latency 2 cycles from the grant.
module sine_rom_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        rom_cs,
  output logic [ADDR_WIDTH-1:0]       rom_addr,
  input  logic [DATA_WIDTH-1:0]       rom_dout,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic                        rdata_valid,
  output logic [1:0]                  rdata_id
);

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [1:0]            ptr_reg, ptr_next;
  logic [ADDR_WIDTH-1:0] rom_addr_reg;
  logic                  grant_any;
  logic [1:0]            win_idx;
  logic                  s1_valid_reg;
  logic [1:0]            s1_id_reg;
  logic                  s1_valid;

  // Unpack the flat address bus into one entry per requester
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_addr
      assign addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

  // Round-robin search starting at ptr; reset and enable=0 suppress any grant
  always_comb begin
    logic [1:0] cand;
    gnt       = '0;
    grant_any = 1'b0;
    win_idx   = ptr_reg;
    cand      = ptr_reg;
    if (!reset && enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = ptr_reg + 2'(k);
        if (!grant_any && req[cand]) begin
          grant_any = 1'b1;
          win_idx   = cand;
        end
      end
    end
    if (grant_any) gnt[win_idx] = 1'b1;
    ptr_next = grant_any ? (win_idx + 2'd1) : ptr_reg;
  end

  assign rom_cs   = grant_any;
  assign rom_addr = grant_any ? addr_arr[win_idx] : rom_addr_reg;

  // Pointer and the address that rom_addr falls back to between grants
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg      <= 2'd0;
      rom_addr_reg <= '0;
    end else begin
      ptr_reg      <= ptr_next;
      rom_addr_reg <= rom_addr;
    end
  end

  // Track which read is in flight; its ROM data arrives the next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_id_reg    <= 2'd0;
    end else begin
      s1_valid_reg <= grant_any;
      if (grant_any) s1_id_reg <= win_idx;
    end
  end

  // A reset asserted while data is in flight drops that read immediately
  assign s1_valid = s1_valid_reg & ~reset;

`ifdef SINE_ROM_ARB_OUTREG_EN
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic                  out_valid_reg;
  logic [1:0]            out_id_reg;

  // Extra output stage: data and id are captured only for valid reads and held otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_id_reg    <= 2'd0;
    end else begin
      out_valid_reg <= s1_valid;
      if (s1_valid) begin
        out_data_reg <= rom_dout;
        out_id_reg   <= s1_id_reg;
      end
    end
  end

  assign rdata       = out_data_reg;
  assign rdata_valid = out_valid_reg;
  assign rdata_id    = out_id_reg;
`else
  logic [DATA_WIDTH-1:0] data_hold_reg;

  // Keep the last returned word so rdata stays stable between valid pulses
  always_ff @(posedge clk) begin
    if (reset) data_hold_reg <= '0;
    else if (s1_valid) data_hold_reg <= rom_dout;
  end

  assign rdata       = s1_valid ? rom_dout : data_hold_reg;
  assign rdata_valid = s1_valid;
  assign rdata_id    = s1_id_reg;
`endif

endmodule

// File: doc/sine_rom_arbiter.md
SINE_ROM_ARBITER -- requirements
Module: sine_rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, ROM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, ROM data width.
REQ-003 SHALL have parameter NUM_REQ, fixed at 4, requester count.
REQ-004 SHALL have port clk, input, 1, single clock, all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port enable, input, 1, high allows new grants.
REQ-007 SHALL have port req, input, 4, per-requester read request, one bit per requester.
REQ-008 SHALL have port req_addr, input, 4*ADDR_WIDTH, requester i address in bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 SHALL have port gnt, output, 4, one-hot grant, combinational in the cycle of acceptance.
REQ-010 SHALL have port rom_cs, output, 1, ROM chip select.
REQ-011 SHALL have port rom_addr, output, ADDR_WIDTH, ROM address.
REQ-012 SHALL have port rom_dout, input, DATA_WIDTH, ROM read data, valid 1 cycle after rom_cs.
REQ-013 SHALL have port rdata, output, DATA_WIDTH, returned read data.
REQ-014 SHALL have port rdata_valid, output, 1, rdata qualifier, single-cycle pulse per accepted request.
REQ-015 SHALL have port rdata_id, output, 2, index of the requester owning rdata.

Function
REQ-016 SHALL grant at most one requester per cycle; gnt[i] high means request i accepted this cycle.
REQ-017 SHALL arbitrate round-robin: search starts at pointer ptr, wraps 3->0; first asserted req wins.
REQ-018 SHALL update ptr to (granted index + 1) mod 4 on the clock edge after a grant; ptr holds when nothing is granted.
REQ-019 SHALL drive rom_cs=1 and rom_addr=winner's req_addr in the grant cycle; rom_cs=0 and rom_addr holds its last value otherwise.
REQ-020 SHALL assert rdata_valid with rdata=rom_dout and rdata_id=granted index exactly 1 cycle after the grant (base latency 1).
REQ-021 SHALL allow back-to-back grants every cycle, giving throughput of 1 read/cycle.
REQ-022 SHALL have requester hold req and req_addr stable until gnt is seen; req high in a cycle after gnt is a new request.
REQ-023 SHALL make enable=0 block new grants (gnt=0, rom_cs=0) while in-flight reads still complete and ptr holds.
REQ-024 SHALL make req=0 in all bits produce no grant, no ROM access and no later rdata_valid.
REQ-025 SHALL keep rdata holding its last value while rdata_valid=0.

Reset
REQ-026 SHALL on reset set ptr=0, gnt=0, rom_cs=0, rom_addr=0, rdata=0, rdata_valid=0 and rdata_id=0.
REQ-027 SHALL make reset mid-operation discard all in-flight reads: rdata_valid stays 0 in the following cycles, and no grant is given in the reset cycle.

Configuration
REQ-028 SHALL, when SINE_ROM_ARB_OUTREG_EN is defined, add a register stage on rdata, rdata_valid and rdata_id, giving latency 2 cycles from grant; without the macro, latency is 1 cycle per REQ-020.
REQ-029 SHALL keep throughput, ordering and reset values identical with or without SINE_ROM_ARB_OUTREG_EN.

Verification
REQ-030 SHALL cover single request: ROM model dout=addr+32'h100, req=4'b0010, addr1=8'h40 -> gnt=4'b0010 same cycle; next cycle rdata_valid=1, rdata=32'h140, rdata_id=1.
REQ-031 SHALL cover fairness: req=4'b1111 held for 8 cycles from reset -> gnt sequence 0,1,2,3,0,1,2,3 with rdata_valid high on 8 consecutive cycles.
REQ-032 SHALL cover pointer wrap: ptr=3 (after a grant to 2), req=4'b1001 -> gnt=4'b1000, then gnt=4'b0001.
REQ-033 SHALL cover enable: enable=0 for 3 cycles with req=4'b0100 -> gnt=0, rom_cs=0; on enable=1 -> gnt=4'b0100 the same cycle.
REQ-034 SHALL cover reset mid-flight: grant to requester 2, then reset asserted the next cycle -> rdata_valid=0, ptr=0, and the next req=4'b0101 gives gnt=4'b0001.
REQ-035 SHALL cover output-register mode: with SINE_ROM_ARB_OUTREG_EN, repeat REQ-030 -> rdata_valid appears 2 cycles after gnt with rdata=32'h140.
